// File: rtl/fan_pkg.sv
// Shared types and helpers for the fan tachometer front end.
// Holds the measurement FSM encoding, default sizing and the saturating increment.
package fan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_t;

  localparam int NUM_CH_DEF    = 2;
  localparam int CNT_W_DEF     = 8;
  localparam int GATE_W_DEF    = 16;
  localparam int DEB_LEN_DEF   = 3;
  localparam int STALL_WIN_DEF = 4;

  // Increments by one when inc is set, never exceeding max_val.
  function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                          input logic        inc,
                                          input logic [31:0] max_val);
    if (inc && (val < max_val))
      return val + 32'd1;
    return val;
  endfunction

endpackage

// File: rtl/tach_filter.sv
// One tach channel: two-flop synchroniser, debounce filter and edge detector.
// edge_o is a single-cycle pulse on the filtered level, rising-only or both edges.
module tach_filter
  import fan_pkg::*;
#(
  parameter int DEB_LEN = DEB_LEN_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tach_i,
  input  logic edge_sel_i,
  output logic edge_o
);

  localparam int DW = (DEB_LEN < 2) ? 1 : $clog2(DEB_LEN + 1);

  logic          sync1;
  logic          sync2;
  logic          filt;
  logic          filt_d;
  logic [DW-1:0] deb_cnt;

  // The filtered level follows the synced input only after DEB_LEN disagreeing samples in a row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      filt    <= 1'b0;
      filt_d  <= 1'b0;
      deb_cnt <= '0;
    end else begin
      sync1  <= tach_i;
      sync2  <= sync1;
      filt_d <= filt;
      if (sync2 != filt) begin
        if (deb_cnt == DW'(DEB_LEN - 1)) begin
          filt    <= sync2;
          deb_cnt <= '0;
        end else begin
          deb_cnt <= deb_cnt + DW'(1);
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

  assign edge_o = edge_sel_i ? (filt ^ filt_d) : (filt & ~filt_d);

endmodule

// File: rtl/fan_tach_meas.sv
// Multi-channel fan tachometer: counts filtered tach edges per gate window and
// hands per-channel counts plus stall flags to the consumer over valid/ready.
module fan_tach_meas
  import fan_pkg::*;
#(
  parameter int NUM_CH    = NUM_CH_DEF,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int GATE_W    = GATE_W_DEF,
  parameter int DEB_LEN   = DEB_LEN_DEF,
  parameter int STALL_WIN = STALL_WIN_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ena,
  input  logic [NUM_CH-1:0]       tach_i,
  input  logic [GATE_W-1:0]       gate_len_i,
  input  logic                    edge_sel_i,
  output logic [NUM_CH*CNT_W-1:0] cnt_o,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic                    overrun_o,
  output logic [NUM_CH-1:0]       stall_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam int SW = (STALL_WIN < 2) ? 1 : $clog2(STALL_WIN + 1);

  state_t              state;
  state_t              state_next;
  logic [GATE_W-1:0]   gate_cnt;
  logic [GATE_W-1:0]   gate_len_q;
  logic [GATE_W-1:0]   gate_len_eff;
  logic [NUM_CH-1:0]   edge_pulse;
  logic [CNT_W-1:0]    acc      [NUM_CH];
  logic [CNT_W-1:0]    acc_next [NUM_CH];
  logic [SW-1:0]       stall_cnt[NUM_CH];
  logic [SW-1:0]       stall_inc[NUM_CH];
  logic [NUM_CH*CNT_W-1:0] snap;
  logic                win_end;
  logic                run_end;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    tach_filter #(.DEB_LEN(DEB_LEN)) u_filter (
      .clk        (clk),
      .rst_n      (rst_n),
      .tach_i     (tach_i[g]),
      .edge_sel_i (edge_sel_i),
      .edge_o     (edge_pulse[g])
    );
  end

  assign gate_len_eff = (gate_len_i == '0) ? GATE_W'(1) : gate_len_i;
  assign win_end      = ena && (state != IDLE) && (gate_cnt == gate_len_q - GATE_W'(1));
  assign run_end      = win_end && (state == RUN);

  // An edge landing in the window-end cycle is folded into the closing window's value.
  always_comb begin
    snap = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      acc_next[i]  = CNT_W'(sat_inc(32'(acc[i]), edge_pulse[i], 32'(CNT_MAX)));
      stall_inc[i] = SW'(sat_inc(32'(stall_cnt[i]), 1'b1, 32'(STALL_WIN)));
      snap[i*CNT_W +: CNT_W] = acc_next[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (ena) state_next = PRIME;
      PRIME:   if (win_end) state_next = RUN;
      RUN:     state_next = RUN;
      default: state_next = IDLE;
    endcase
    if (!ena) state_next = IDLE;
  end

  // The window length is captured while idle and at every window end, so it is fixed per window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate_cnt   <= '0;
      gate_len_q <= GATE_W'(1);
    end else if ((state == IDLE) || !ena || win_end) begin
      gate_cnt   <= '0;
      gate_len_q <= gate_len_eff;
    end else begin
      gate_cnt <= gate_cnt + GATE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        acc[i]       <= '0;
        stall_cnt[i] <= '0;
      end
      stall_o <= '0;
    end else if ((state == IDLE) || !ena) begin
      for (int i = 0; i < NUM_CH; i++) begin
        acc[i]       <= '0;
        stall_cnt[i] <= '0;
      end
      stall_o <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (win_end) begin
          acc[i] <= '0;
          if (state == RUN) begin
            if (acc_next[i] == '0) begin
              stall_cnt[i] <= stall_inc[i];
              stall_o[i]   <= (stall_inc[i] == SW'(STALL_WIN));
            end else begin
              stall_cnt[i] <= '0;
              stall_o[i]   <= 1'b0;
            end
          end
        end else begin
          acc[i] <= acc_next[i];
        end
      end
    end
  end

  // A new snapshot always wins over an acceptance in the same cycle; losing an unread one is sticky.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_o     <= '0;
      valid_o   <= 1'b0;
      overrun_o <= 1'b0;
    end else if (run_end) begin
      cnt_o   <= snap;
      valid_o <= 1'b1;
      if (valid_o && !ready_i) overrun_o <= 1'b1;
    end else if (valid_o && ready_i) begin
      valid_o <= 1'b0;
    end
  end

endmodule

// File: doc/fan_tach_meas.md
Name: fan_tach_meas

Overview:
Multi-channel fan tachometer front end for the next-generation fan controller. It synchronises and debounces N tach inputs, then counts tach edges over a programmable gate window. Per-channel speed counts are delivered to the PID stage through a valid/ready handshake, together with per-channel stall flags. It replaces the single fixed-channel speed counter and adds channel count, edge mode, debounce, stall detection and overrun reporting.

Parameters:
NUM_CH, 2, number of tach channels
CNT_W, 8, width of each per-channel edge count
GATE_W, 16, width of the gate-length input and the gate counter
DEB_LEN, 3, consecutive equal samples required to accept a level change (≥1)
STALL_WIN, 4, consecutive zero-count windows before a stall is flagged (≥1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ena  in  1  measurement enable
tach_i  in  NUM_CH  raw asynchronous tach inputs
gate_len_i  in  GATE_W  window length in cycles; 0 is treated as 1
edge_sel_i  in  1  0 = count rising edges only, 1 = count both edges
cnt_o  out  NUM_CH*CNT_W  snapshot counts, ch0 in LSBs
valid_o  out  1  snapshot available
ready_i  in  1  consumer accepts the snapshot
overrun_o  out  1  sticky: a snapshot was overwritten before it was accepted
stall_o  out  NUM_CH  per-channel stall flag

Behaviour:
- Reset (async, rst_n=0): all outputs 0, sync/filter levels 0, FSM=IDLE, all counters 0.
- Per channel: 2-flop synchroniser, then debounce.
  - The filtered level toggles after DEB_LEN consecutive synced samples differ from it.
  - Latency from raw edge to filtered edge: 2+DEB_LEN cycles.
- Edge pulse (1 cycle):
  - edge_sel_i=0: filtered rising edge only.
  - edge_sel_i=1: either filtered edge.
  - edge_sel_i is sampled live.
- FSM states:
  - IDLE: gate counter, accumulators and stall counters held at 0. Goes to PRIME when ena=1.
  - PRIME: one full window runs. Its results are discarded and valid_o is not raised, so the debounce settles. Goes to RUN at window end.
  - RUN: windows repeat back-to-back.
  - ena=0 in any state: returns to IDLE next cycle. The current window is aborted with no snapshot. valid_o, cnt_o and overrun_o keep their values. stall_o clears.
- Gate:
  - G = max(gate_len_i,1), latched at each window start.
  - Gate counter runs 0..G-1. The cycle with gate counter = G-1 is the window-end cycle.
  - The next window starts the following cycle with no dead cycle.
- Accumulators:
  - Count +1 per edge pulse, saturating at 2^CNT_W-1.
  - An edge in the window-end cycle belongs to the closing window.
  - The snapshot value is the saturated sum acc+edge. The accumulator restarts at 0.
- Handshake (RUN window end):
  - cnt_o is loaded and valid_o=1 next cycle.
  - valid_o stays high until a cycle with valid_o&ready_i. valid_o falls the cycle after that.
  - If a window end coincides with the accepting cycle, the new snapshot wins and valid_o stays 1. This is not an overrun.
  - If a window end occurs while valid_o=1 and ready_i=0, cnt_o is overwritten and overrun_o sets.
  - overrun_o clears only on reset.
- Stall, per channel, evaluated at each RUN window end:
  - A zero snapshot increments a saturating counter (capped at STALL_WIN).
  - Any nonzero snapshot clears the counter and stall_o.
  - stall_o=1 when the counter reaches STALL_WIN, updated with cnt_o.
- Reset mid-window: everything returns to reset values immediately, with no partial snapshot.

Decomposition:
- Package fan_pkg:
  - FSM state enum (IDLE, PRIME, RUN).
  - Default parameter constants.
  - Helper function for the saturating increment.
- Sub-module tach_filter, one instance per channel via a generate loop:
  - Contains the synchroniser, debounce counter and edge detector.
  - Ports: clk, rst_n, tach_i, edge_sel_i, edge_o.
- Top: FSM, gate counter, accumulators, snapshot/handshake, stall counters.

Test Plan:
1. ch0 square wave, period 20 (10 high/10 low), gate_len_i=100, edge_sel_i=0, ready_i=1 -> first valid_o after PRIME+RUN windows (~200 cycles); cnt_o[7:0]=5 every window; ch1 static -> 0.
2. Same stimulus with edge_sel_i=1 -> cnt_o[7:0]=10; a 2-cycle glitch injected into ch1 -> ch1 count stays 0 (DEB_LEN=3).
3. ch0 period 8 (4/4), gate_len_i=4000, both edges -> 1000 edges saturate, cnt_o[7:0]=255; gate_len_i=0 -> 1-cycle windows, no hang.
4. ch1 held low, ch0 running, ready_i=1 -> stall_o[1] rises with the 4th RUN snapshot; toggling ch1 again -> stall_o[1]=0 at the first nonzero window; stall_o[0] stays 0 throughout.
5. ready_i=0 across 2 window ends -> valid_o held, overrun_o=1, cnt_o holds the latest window; raise ready_i -> valid_o drops next cycle, overrun_o stays 1.
6. Assert rst_n=0 mid-window at gate count 50 -> all outputs 0 immediately; after release with ena=1 -> PRIME window repeats before the next valid_o; ena=0 mid-RUN -> no snapshot, stall_o cleared.
